// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared types and helpers for the HBM read scheduler
package floo_pkg;

  typedef enum logic {
    HBM_IDLE = 1'b0,
    HBM_HOLD = 1'b1
  } hbm_sched_state_e;

  // Outstanding counter must be able to hold the value max_txns itself.
  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns) + 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - small synchronous FIFO used to track burst return order
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    data_o = mem_q[rd_ptr_q];
    if (FALL_THROUGH && empty_o && push_i) data_o = data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH-1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH-1)) ? '0 : rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/floo_hbm_rd_scheduler.sv
// rtl/floo_hbm_rd_scheduler.sv - round-robin AR arbiter for one HBM channel with in-order R routing
module floo_hbm_rd_scheduler
  import floo_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTxns   = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  req_ar_valid_i,
  output logic [NumReq-1:0]                  req_ar_ready_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]   req_ar_addr_i,
  input  logic [NumReq-1:0][7:0]             req_ar_len_i,
  output logic                               hbm_ar_valid_o,
  input  logic                               hbm_ar_ready_i,
  output logic [AddrWidth-1:0]               hbm_ar_addr_o,
  output logic [7:0]                         hbm_ar_len_o,
  input  logic                               hbm_r_valid_i,
  output logic                               hbm_r_ready_o,
  input  logic [DataWidth-1:0]               hbm_r_data_i,
  input  logic                               hbm_r_last_i,
  output logic [NumReq-1:0]                  req_r_valid_o,
  input  logic [NumReq-1:0]                  req_r_ready_i,
  output logic [DataWidth-1:0]               req_r_data_o,
  output logic                               req_r_last_o,
  output logic                               busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = cnt_width(MaxTxns);

  hbm_sched_state_e state_q, state_d;
  logic [IdxW-1:0]  last_grant_q, hold_idx_q, grant_idx, cand_idx, ar_idx, r_head;
  logic [CntW-1:0]  outstanding_q;
  logic             found, can_issue, ar_valid, ar_fire, hold_load, r_pop;
  logic             fifo_full, fifo_empty;
  int               cand;

  assign can_issue = (outstanding_q < CntW'(MaxTxns)) && !fifo_full;

  always_comb begin
    state_d   = state_q;
    grant_idx = last_grant_q;
    cand_idx  = '0;
    cand      = 0;
    found     = 1'b0;
    ar_valid  = 1'b0;
    ar_idx    = last_grant_q;
    hold_load = 1'b0;

    // Search starts one past the last winner so every requester gets a turn.
    for (int i = 1; i <= int'(NumReq); i++) begin
      cand     = (int'(last_grant_q) + i) % int'(NumReq);
      cand_idx = IdxW'(cand);
      if (!found && req_ar_valid_i[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end

    case (state_q)
      HBM_IDLE: begin
        ar_idx = grant_idx;
        if (found && can_issue) begin
          ar_valid = 1'b1;
          if (!hbm_ar_ready_i) begin
            state_d   = HBM_HOLD;
            hold_load = 1'b1;
          end
        end
      end
      HBM_HOLD: begin
        ar_idx   = hold_idx_q;
        ar_valid = 1'b1;
        if (hbm_ar_ready_i) state_d = HBM_IDLE;
      end
      default: state_d = HBM_IDLE;
    endcase
  end

  assign ar_fire        = ar_valid && hbm_ar_ready_i && !rst_i;
  assign hbm_ar_valid_o = ar_valid && !rst_i;
  assign hbm_ar_addr_o  = req_ar_addr_i[ar_idx];
  assign hbm_ar_len_o   = req_ar_len_i[ar_idx];

  always_comb begin
    req_ar_ready_o         = '0;
    req_ar_ready_o[ar_idx] = ar_fire;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= HBM_IDLE;
      last_grant_q <= IdxW'(NumReq - 1);
      hold_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire)   last_grant_q <= ar_idx;
      if (hold_load) hold_idx_q   <= grant_idx;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxW),
    .DEPTH        (MaxTxns)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ar_fire),
    .data_i  (ar_idx),
    .pop_i   (r_pop),
    .data_o  (r_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Beats are only steered to the requester owning the oldest tracked burst.
  always_comb begin
    req_r_valid_o = '0;
    hbm_r_ready_o = 1'b0;
    if (!fifo_empty && !rst_i) begin
      req_r_valid_o[r_head] = hbm_r_valid_i;
      hbm_r_ready_o         = req_r_ready_i[r_head];
    end
  end

  assign r_pop        = hbm_r_valid_i && hbm_r_ready_o && hbm_r_last_i;
  assign req_r_data_o = hbm_r_data_i;
  assign req_r_last_o = hbm_r_last_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({ar_fire, r_pop})
        2'b10:   outstanding_q <= outstanding_q + CntW'(1);
        2'b01:   outstanding_q <= outstanding_q - CntW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign busy_o = ((outstanding_q != '0) || (state_q == HBM_HOLD)) && !rst_i;

endmodule

// File: doc/floo_hbm_rd_scheduler.md
FLOO_HBM_RD_SCHEDULER -- requirements
Module: floo_hbm_rd_scheduler

Interface
REQ-001 Parameter NumReq, default 2, number of read requesters sharing one HBM channel (2..8).
REQ-002 Parameter AddrWidth, default 48, AR address width.
REQ-003 Parameter DataWidth, default 64, R data width.
REQ-004 Parameter MaxTxns, default 8, maximum outstanding HBM bursts; power of two, 2..32.
REQ-005 Clocking SHALL be one clock with an asynchronous, active-high reset.
REQ-006 clk_i  in  1  sole clock; all state samples on its rising edge.
REQ-007 rst_i  in  1  asynchronous reset, active-high.
REQ-008 req_ar_valid_i  in  NumReq  per-requester AR valid.
REQ-009 req_ar_ready_o  out  NumReq  per-requester AR ready.
REQ-010 req_ar_addr_i  in  NumReq x AddrWidth  per-requester burst address.
REQ-011 req_ar_len_i  in  NumReq x 8  per-requester AXI burst length (beats-1).
REQ-012 hbm_ar_valid_o / hbm_ar_ready_i  out / in  1 / 1  HBM AR handshake.
REQ-013 hbm_ar_addr_o, hbm_ar_len_o  out  AddrWidth, 8  forwarded AR payload.
REQ-014 hbm_r_valid_i / hbm_r_ready_o  in / out  1 / 1  HBM R handshake.
REQ-015 hbm_r_data_i, hbm_r_last_i  in  DataWidth, 1  HBM R payload; HBM returns bursts in AR order.
REQ-016 req_r_valid_o / req_r_ready_i  out / in  NumReq / NumReq  per-requester R handshake.
REQ-017 req_r_data_o, req_r_last_o  out  DataWidth, 1  R payload, broadcast to all requesters.
REQ-018 busy_o  out  1  high when any burst is outstanding or AR is held.

Function
REQ-019 AR FSM states are IDLE and HOLD.
REQ-020 IDLE: if any req_ar_valid_i is set and outstanding < MaxTxns, grant round-robin, starting at the index after the last grant, and drive hbm_ar_valid_o high in the same cycle.
REQ-021 IDLE with hbm_ar_ready_i high: the handshake completes combinationally, req_ar_ready_o[g] is set, and the FSM stays in IDLE.
REQ-022 IDLE with hbm_ar_ready_i low: the FSM enters HOLD, registers the grant, and keeps addr/len/valid stable until the handshake, regardless of other requesters.
REQ-023 HOLD exits to IDLE on the hbm_ar_ready_i handshake.
REQ-024 The last-grant pointer updates only on a completed AR handshake; its reset value is NumReq-1, so index 0 wins first.
REQ-025 On each AR handshake, the granted index is pushed into the order FIFO (depth MaxTxns) and the outstanding counter increments.
REQ-026 When outstanding == MaxTxns, hbm_ar_valid_o SHALL be 0 and all req_ar_ready_o SHALL be 0.
REQ-027 R routing: while the order FIFO is non-empty, req_r_valid_o[head] = hbm_r_valid_i and hbm_r_ready_o = req_r_ready_i[head]; all other req_r_valid_o bits are 0.
REQ-028 When the FIFO is empty, hbm_r_ready_o SHALL be 0 and all req_r_valid_o SHALL be 0; R is never accepted without a tracked burst.
REQ-029 An R handshake with hbm_r_last_i pops the FIFO and decrements outstanding.
REQ-030 A simultaneous AR push and R-last pop in one cycle leaves outstanding unchanged; both FIFO pointers advance.
REQ-031 The outstanding counter is clog2(MaxTxns)+1 bits wide; FIFO pointers wrap modulo MaxTxns.
REQ-032 Zero-cycle latency: AR and R paths are combinational through the scheduler, with no added pipeline stage.
REQ-033 busy_o = (outstanding != 0) | (state == HOLD).

Reset
REQ-034 While rst_i is high: state = IDLE, outstanding = 0, FIFO empty, last grant = NumReq-1.
REQ-035 While rst_i is high, all valid/ready outputs and busy_o SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL discard all tracking; the HBM side is reset by the same rst_i.

Structure
REQ-037 floo_pkg SHALL hold the state enum (hbm_sched_state_e) and a helper function computing the counter width.
REQ-038 The order FIFO SHALL be one sub-module, fifo_v3, instantiated with FALL_THROUGH = 0 and DATA_WIDTH = clog2(NumReq).

Verification
REQ-039 Requesters 0 and 1 both assert AR at cycle 5 with hbm_ar_ready_i held at 1: grants are 0,1,0,1 on successive cycles, and after reset requester 0 is granted first.
REQ-040 hbm_ar_ready_i = 0 for 3 cycles with requester 0 granted and requester 1 valid: addr/len stay stable for 3 cycles and requester 1 is not granted until cycle 4.
REQ-041 MaxTxns = 8, nine single-beat ARs with R withheld: exactly 8 handshakes occur, the 9th is stalled, busy_o = 1, and the 9th issues the cycle after the first R-last.
REQ-042 Bursts issued in order req1 (len 3), req0 (len 0): 4 beats go to requester 1, then 1 beat to requester 0, and other valids stay 0.
REQ-043 A new AR handshake coincides with an R-last handshake at outstanding = 3: outstanding remains 3.
REQ-044 rst_i pulsed while 2 bursts are outstanding: all outputs go 0 immediately, and after release outstanding = 0 and hbm_r_ready_o = 0.
